// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: default geometry, entry
// record and the pc index/tag split reused by the direction predictor.
package btb_pkg;

  localparam int BTB_IDX_BITS = 4;
  localparam int BTB_TAG_W    = 32 - BTB_IDX_BITS;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  // pc is a word address, so the index is taken straight from the low bits.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_bits);
    return pc & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_bits);
    return pc >> idx_bits;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-high clear; holds at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency lookup for decode,
// training from execute resolution, and saturating lookup/hit statistics.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int IDX_BITS = BTB_IDX_BITS,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             is_branch,
  output logic             hit,
  output logic [31:0]      target,
  input  logic [31:0]      past_pc,
  input  logic             past_is_branch,
  input  logic             past_taken,
  input  logic [31:0]      past_target,
  input  logic             inval_all,
  output logic [CNT_W-1:0] lookup_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  logic [IDX_BITS-1:0] w_rd_idx;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [IDX_BITS-1:0] w_wr_idx;
  logic [TAG_W-1:0]    w_wr_tag;
  logic                w_wr_match;
  logic                w_hit;
  logic [31:0]         w_target;

  assign w_rd_idx = IDX_BITS'(pc_index(pc, IDX_BITS));
  assign w_rd_tag = TAG_W'(pc_tag(pc, IDX_BITS));
  assign w_wr_idx = IDX_BITS'(pc_index(past_pc, IDX_BITS));
  assign w_wr_tag = TAG_W'(pc_tag(past_pc, IDX_BITS));

  assign w_wr_match = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_hit    = 1'b0;
    w_target = 32'd0;
    if (r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag)) begin
      w_hit    = 1'b1;
      w_target = r_target[w_rd_idx];
    end
  end

  assign hit    = w_hit;
  assign target = w_target;

  // Valid bits live in one flop vector so reset and flush clear them in a
  // single cycle; a flush drops any coincident training.
  always_ff @(posedge clock) begin
    if (reset || inval_all) begin
      r_valid <= '0;
    end else if (past_is_branch) begin
      if (past_taken) begin
        r_valid[w_wr_idx] <= 1'b1;
      end else if (w_wr_match) begin
        r_valid[w_wr_idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag/target storage is deliberately not reset; the valid vector
  // guards it, which keeps the arrays plain enable-only flops.
  always_ff @(posedge clock) begin
    if (!reset && !inval_all && past_is_branch && past_taken) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= past_target;
    end
  end

  sat_counter #(.W(CNT_W)) u_lookup_count (
    .clock   (clock),
    .reset   (reset),
    .i_en    (is_branch),
    .o_count (lookup_count)
  );

  sat_counter #(.W(CNT_W)) u_hit_count (
    .clock   (clock),
    .reset   (reset),
    .i_en    (is_branch && w_hit),
    .o_count (hit_count)
  );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: expected values are queued when a
// step is driven and popped as the DUT's lookup and counter outputs appear.
module tb_branch_target_buffer;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clock;
  logic             reset;
  logic [31:0]      pc;
  logic             is_branch;
  logic             hit;
  logic [31:0]      target;
  logic [31:0]      past_pc;
  logic             past_is_branch;
  logic             past_taken;
  logic [31:0]      past_target;
  logic             inval_all;
  logic [CNT_W-1:0] lookup_count;
  logic [CNT_W-1:0] hit_count;

  int checks = 0;
  int errors = 0;

  string       exp_tag_q [$];
  logic [31:0] exp_val_q [$];

  int exp_lookups = 0;
  int exp_hits    = 0;

  branch_target_buffer #(.IDX_BITS(4), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .is_branch      (is_branch),
    .hit            (hit),
    .target         (target),
    .past_pc        (past_pc),
    .past_is_branch (past_is_branch),
    .past_taken     (past_taken),
    .past_target    (past_target),
    .inval_all      (inval_all),
    .lookup_count   (lookup_count),
    .hit_count      (hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int sat_inc(input int v);
    return (v >= int'(CNT_MAX)) ? v : v + 1;
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    checks++;
    if (exp_val_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed=%0h", observed);
    end else begin
      tag      = exp_tag_q.pop_front();
      expected = exp_val_q.pop_front();
      assert (observed === expected) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
    end
  endtask

  // One clock cycle: drive all inputs, check the combinational lookup before
  // the edge, then check both counters after it.
  task automatic step(input string name,
                      input logic [31:0] a_pc, input logic a_br,
                      input logic a_pbr, input logic a_ptk,
                      input logic [31:0] a_ppc, input logic [31:0] a_ptgt,
                      input logic a_inv, input logic a_rst,
                      input logic e_hit, input logic [31:0] e_tgt);
    pc             = a_pc;
    is_branch      = a_br;
    past_is_branch = a_pbr;
    past_taken     = a_ptk;
    past_pc        = a_ppc;
    past_target    = a_ptgt;
    inval_all      = a_inv;
    reset          = a_rst;
    push_exp({name, "_hit"}, {31'd0, e_hit});
    push_exp({name, "_target"}, e_tgt);
    if (a_rst) begin
      exp_lookups = 0;
      exp_hits    = 0;
    end else if (a_br) begin
      exp_lookups = sat_inc(exp_lookups);
      if (e_hit) exp_hits = sat_inc(exp_hits);
    end
    push_exp({name, "_lookup_count"}, 32'(exp_lookups));
    push_exp({name, "_hit_count"}, 32'(exp_hits));
    @(negedge clock);
    check({31'd0, hit});
    check(target);
    @(posedge clock);
    #1;
    check(32'(lookup_count));
    check(32'(hit_count));
  endtask

  task automatic lookup(input string name, input logic [31:0] a_pc,
                        input logic e_hit, input logic [31:0] e_tgt);
    step(name, a_pc, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, e_hit, e_tgt);
  endtask

  initial begin
    pc = 0; is_branch = 0; past_pc = 0; past_is_branch = 0; past_taken = 0;
    past_target = 0; inval_all = 0; reset = 1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    push_exp("reset_lookup_count", 32'd0);
    push_exp("reset_hit_count", 32'd0);
    check(32'(lookup_count));
    check(32'(hit_count));
    reset = 0;

    lookup("cold", 32'h40, 1'b0, 32'd0);
    step("train_rdw", 32'h40, 0, 1, 1, 32'h40, 32'h120, 0, 0, 1'b0, 32'd0);
    lookup("trained", 32'h40, 1'b1, 32'h120);

    step("alias_train", 32'h50, 0, 1, 1, 32'h50, 32'h200, 0, 0, 1'b0, 32'd0);
    lookup("alias_old", 32'h40, 1'b0, 32'd0);
    lookup("alias_new", 32'h50, 1'b1, 32'h200);

    step("nt_rdw", 32'h50, 1, 1, 0, 32'h50, 32'h0, 0, 0, 1'b1, 32'h200);
    lookup("nt_cleared", 32'h50, 1'b0, 32'd0);
    step("retrain", 32'h41, 0, 1, 1, 32'h40, 32'h120, 0, 0, 1'b0, 32'd0);
    step("nt_other_tag", 32'h40, 0, 1, 0, 32'h50, 32'h0, 0, 0, 1'b1, 32'h120);
    step("no_branch_upd", 32'h40, 1, 0, 1, 32'h40, 32'hdead, 0, 0, 1'b1, 32'h120);
    lookup("no_branch_kept", 32'h40, 1'b1, 32'h120);

    step("nt_clear40", 32'h40, 0, 1, 0, 32'h40, 32'h0, 0, 0, 1'b1, 32'h120);
    step("same_cycle", 32'h40, 1, 1, 1, 32'h40, 32'h300, 0, 0, 1'b0, 32'd0);
    lookup("after_write", 32'h40, 1'b1, 32'h300);

    step("train7", 32'h07, 0, 1, 1, 32'h07, 32'h77, 0, 0, 1'b0, 32'd0);
    lookup("hit7", 32'h07, 1'b1, 32'h77);
    step("inval_upd", 32'h07, 1, 1, 1, 32'h23, 32'h99, 1, 0, 1'b1, 32'h77);
    lookup("inval_40", 32'h40, 1'b0, 32'd0);
    lookup("inval_07", 32'h07, 1'b0, 32'd0);
    lookup("inval_dropped", 32'h23, 1'b0, 32'd0);
    step("train23", 32'h23, 0, 1, 1, 32'h23, 32'h99, 0, 0, 1'b0, 32'd0);
    lookup("hit23", 32'h23, 1'b1, 32'h99);

    step("reset_upd", 32'h23, 1, 1, 1, 32'h07, 32'h55, 0, 1, 1'b1, 32'h99);
    reset = 0;
    lookup("post_reset23", 32'h23, 1'b0, 32'd0);
    lookup("post_reset07", 32'h07, 1'b0, 32'd0);

    step("train9", 32'h09, 0, 1, 1, 32'h09, 32'habc, 0, 0, 1'b0, 32'd0);
    for (int i = 0; i < 70; i++) begin
      lookup("sat_run", 32'h09, 1'b1, 32'habc);
    end
    lookup("sat_hold", 32'h01, 1'b0, 32'd0);

    if (exp_val_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_val_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
